// File: rtl/bram_line_requester_pkg.sv
//==============================================================================
// Module   : bram_line_requester_pkg
// Summary  : Shared op/state encodings and line geometry for the cache-to-BRAM
//            line requester, the cache controller and the BRAM.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package bram_line_requester_pkg;

    localparam int c_line_addr_size   = 7;
    localparam int c_line_offset_bits = 6;
    localparam int c_line_data_size   = 2 ** (c_line_offset_bits + 3);

    typedef enum logic [1:0] {
        OP_FILL    = 2'b00,
        OP_WB_FILL = 2'b01,
        OP_WB_ONLY = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_HOLD = 3'd1,
        ST_WR_GAP  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/bram_line_requester_if.sv
//==============================================================================
// Module   : bram_line_requester_if
// Summary  : Controller request/response channel plus BRAM port, with the
//            requester as master and the controller/BRAM side as slave.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface bram_line_requester_if
    import bram_line_requester_pkg::*;
#(
    parameter int ADDR_SIZE   = c_line_addr_size,
    parameter int OFFSET_BITS = c_line_offset_bits,
    parameter int DATA_SIZE   = 2 ** (OFFSET_BITS + 3)
);
    localparam int c_aw = ADDR_SIZE + OFFSET_BITS;

    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [c_aw-1:0]      req_addr;
    logic [c_aw-1:0]      req_wb_addr;
    logic [DATA_SIZE-1:0] req_wb_data;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [DATA_SIZE-1:0] resp_data;
    logic                 resp_err;

    logic                 bram_enable;
    logic                 read_enable;
    logic                 write_enable;
    logic [c_aw-1:0]      addr_read;
    logic [c_aw-1:0]      addr_write;
    logic [DATA_SIZE-1:0] data_input;
    logic [DATA_SIZE-1:0] data_mask;
    logic [DATA_SIZE-1:0] data_out;
    logic                 data_ready;

    modport master (
        input  req_valid, req_op, req_addr, req_wb_addr, req_wb_data,
        input  resp_ready, data_out, data_ready,
        output req_ready, resp_valid, resp_data, resp_err,
        output bram_enable, read_enable, write_enable,
        output addr_read, addr_write, data_input, data_mask
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wb_addr, req_wb_data,
        output resp_ready, data_out, data_ready,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  bram_enable, read_enable, write_enable,
        input  addr_read, addr_write, data_input, data_mask
    );

endinterface

`default_nettype wire

// File: rtl/bram_timeout_ctr.sv
//==============================================================================
// Module   : bram_timeout_ctr
// Summary  : Read-wait watchdog; o_expired marks the TIMEOUT-th enabled cycle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bram_timeout_ctr #(
    parameter int TIMEOUT = 1000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_load,
    input  wire logic i_enable,
    output logic      o_expired
);
    localparam int                 c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/bram_line_requester.sv
//==============================================================================
// Module   : bram_line_requester
// Summary  : Cache-side BRAM master: optional victim writeback, then line fill.
//            Define BRAM_TIMEOUT_EN to bound the read wait by TIMEOUT cycles.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bram_line_requester
    import bram_line_requester_pkg::*;
#(
    parameter int ADDR_SIZE   = c_line_addr_size,
    parameter int OFFSET_BITS = c_line_offset_bits,
    parameter int DATA_SIZE   = 2 ** (OFFSET_BITS + 3),
    parameter int TIMEOUT     = 1000
) (
    input wire logic              clk,
    input wire logic              reset,
    bram_line_requester_if.master bus
);
    localparam int              c_aw        = ADDR_SIZE + OFFSET_BITS;
    localparam logic [c_aw-1:0] c_line_mask = {{ADDR_SIZE{1'b1}}, {OFFSET_BITS{1'b0}}};

    state_e               r_state;
    op_e                  r_op;
    logic                 r_hold_last;
    logic [c_aw-1:0]      r_fill_addr;

    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic                 r_resp_err;
    logic [DATA_SIZE-1:0] r_resp_data;
    logic                 r_bram_enable;
    logic                 r_read_enable;
    logic                 r_write_enable;
    logic [c_aw-1:0]      r_addr_read;
    logic [c_aw-1:0]      r_addr_write;
    logic [DATA_SIZE-1:0] r_data_input;
    logic [DATA_SIZE-1:0] r_data_mask;

    logic                 w_expired;

`ifdef BRAM_TIMEOUT_EN
    // Held cleared outside RD_WAIT, so each wait starts counting from zero.
    bram_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_load    (r_state != ST_RD_WAIT),
        .i_enable  (r_state == ST_RD_WAIT),
        .o_expired (w_expired)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_expired        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_FILL;
            r_hold_last    <= 1'b0;
            r_fill_addr    <= '0;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_err     <= 1'b0;
            r_resp_data    <= '0;
            r_bram_enable  <= 1'b0;
            r_read_enable  <= 1'b0;
            r_write_enable <= 1'b0;
            r_addr_read    <= '0;
            r_addr_write   <= '0;
            r_data_input   <= '0;
            r_data_mask    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_op        <= op_e'(bus.req_op);
                        r_fill_addr <= bus.req_addr & c_line_mask;
                        case (op_e'(bus.req_op))
                            OP_FILL: begin
                                r_state       <= ST_RD_WAIT;
                                r_bram_enable <= 1'b1;
                                r_read_enable <= 1'b1;
                                r_addr_read   <= bus.req_addr & c_line_mask;
                            end
                            OP_WB_FILL, OP_WB_ONLY: begin
                                r_state        <= ST_WR_HOLD;
                                r_hold_last    <= 1'b0;
                                r_bram_enable  <= 1'b1;
                                r_write_enable <= 1'b1;
                                r_addr_write   <= bus.req_wb_addr & c_line_mask;
                                r_data_input   <= bus.req_wb_data;
                                r_data_mask    <= '1;
                            end
                            default: begin
                                r_state      <= ST_RESP;
                                r_resp_valid <= 1'b1;
                                r_resp_err   <= 1'b1;
                                r_resp_data  <= '0;
                            end
                        endcase
                    end
                end

                // The BRAM registers its inputs once, so the write is held two cycles.
                ST_WR_HOLD: begin
                    if (!r_hold_last) begin
                        r_hold_last <= 1'b1;
                    end else begin
                        r_state        <= ST_WR_GAP;
                        r_bram_enable  <= 1'b0;
                        r_write_enable <= 1'b0;
                        r_addr_write   <= '0;
                        r_data_input   <= '0;
                        r_data_mask    <= '0;
                    end
                end

                ST_WR_GAP: begin
                    if (r_op == OP_WB_FILL) begin
                        r_state       <= ST_RD_WAIT;
                        r_bram_enable <= 1'b1;
                        r_read_enable <= 1'b1;
                        r_addr_read   <= r_fill_addr;
                    end else begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= '0;
                    end
                end

                ST_RD_WAIT: begin
                    if (bus.data_ready || w_expired) begin
                        r_state       <= ST_RESP;
                        r_resp_valid  <= 1'b1;
                        r_bram_enable <= 1'b0;
                        r_read_enable <= 1'b0;
                        r_addr_read   <= '0;
                        // Data arriving on the expiry cycle still wins.
                        r_resp_err    <= !bus.data_ready;
                        r_resp_data   <= bus.data_ready ? bus.data_out : '0;
                    end
                end

                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= '0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_err     = r_resp_err;
    assign bus.resp_data    = r_resp_data;
    assign bus.bram_enable  = r_bram_enable;
    assign bus.read_enable  = r_read_enable;
    assign bus.write_enable = r_write_enable;
    assign bus.addr_read    = r_addr_read;
    assign bus.addr_write   = r_addr_write;
    assign bus.data_input   = r_data_input;
    assign bus.data_mask    = r_data_mask;

endmodule

`default_nettype wire
